keypad_scan_fifo: RTL and testbench
===================================

# keypad_scan_fifo

Parametrised matrix-keypad scanner with per-frame debounce, a key-event FIFO and a polled status/data register port. Successor to the fixed 4x4 single-key scanner. Supports arbitrary row/column counts, a configurable scan rate and debounce depth, and buffers up to DEPTH key events so a slow polling CPU does not lose keystrokes. It sits between the keypad pins and the CPU's polled I/O read path.

## Interface
- ROWS, 4, number of driven rows (2..8)
- COLS, 4, number of sensed columns (2..8)
- SCAN_DIV, 32768, clk cycles per row slot (>= 4)
- DEBOUNCE, 3, consecutive identical frames required to change the debounced key (1..15)
- DEPTH, 8, event FIFO entries (power of 2, 2..128)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rowwrite  output  ROWS  row drive, one-cold (active-low)
- colread  input  COLS  column sense, active-low, asynchronous to clk
- ack  input  1  CPU acknowledge; acts on its rising edge only
- statusordata  input  1  1 selects the status word on keyout, 0 selects the data word
- keyout  output  16  polled read value

## Operation
- colread passes through a 2-flop synchronizer before use.
- Divider counts 0..SCAN_DIV-1. When the divider reaches SCAN_DIV-1:
  - the synchronized colread is sampled for the current row;
  - rowwrite rotates one-cold left, so bit ROWS-1 wraps to bit 0.
- A frame is ROWS row slots and ends at the sample of row ROWS-1.
- Key code is row*COLS+col, CODE_W = clog2(ROWS*COLS).
- Frame candidate is the lowest-code pressed key in the frame, or NONE. Lower code wins when several keys are held.
- Debounce counter: increments when the candidate equals the previous frame's candidate, otherwise it resets to 1.
- Debounced state machine:
  - IDLE to HELD(K) when candidate K has been seen for DEBOUNCE frames. Pushes press event {rel=0, K}.
  - HELD(K) to IDLE when a candidate other than K has been seen for DEBOUNCE consecutive frames. Pushes release event when the release feature is enabled.
  - HELD(K) never goes directly to HELD(K'). A new press requires a pass through IDLE.
- FIFO entry is {rel, code}.
- Push when full: the event is dropped and sticky overflow is set.
- Pop: rising edge of ack (ack high, registered ack_q low) with statusordata=0 and FIFO non-empty.
  - Ack edge on an empty FIFO: no-op.
- Ack rising edge with statusordata=1: clears overflow and does not pop.
- Push and pop in the same cycle:
  - both take effect and count is unchanged;
  - when full, no overflow is raised.
- Status word:
  - bit0 ready (count != 0);
  - bit1 overflow;
  - bit2 debounced state is HELD;
  - bits[15:8] count, zero-extended;
  - all other bits 0.
- Data word:
  - bits[7:0] head code, zero-extended;
  - bit15 head rel;
  - all bits 0 when the FIFO is empty.
- keyout is combinational from statusordata and the registered state.
- Reset values:
  - rowwrite = all ones except bit0 = 0;
  - divider 0; debounce counter 0; state IDLE; candidate history NONE;
  - FIFO empty; overflow 0; ack_q 0;
  - keyout = 16'h0000.
- Reset mid-frame discards partial samples.
- An ack held high through reset produces a rising edge on the first cycle after reset. On an empty FIFO this is a no-op.

## Timing
- Row slot is SCAN_DIV clk cycles; frame is ROWS*SCAN_DIV cycles.
- Push occurs on the same clk edge as the final sample of the DEBOUNCE-th qualifying frame. ready reads 1 on the following cycle.
- Minimum press-to-ready latency: DEBOUNCE frames plus synchronizer delay (2 cycles) plus 1.
- Pop updates the head on the edge after ack rises. keyout shows the next entry, or 0, one cycle after that edge.
- ack held high pops once. A second pop requires ack to go low for at least 1 cycle.

## Configuration
- KEYPAD_RELEASE_EVENT_EN
  - Defined: the HELD(K) to IDLE transition pushes {rel=1, K}.
  - Undefined: no release events; bit15 of the data word is constant 0; the rel storage bit is removed.
  - Debounce and state transitions are identical in both builds.

## Test plan
- ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; hold row2/col1 (colread bit1 low while rowwrite bit2 low) for 4 frames:
  - status reads 16'h0105;
  - data reads 16'h0009;
  - ack edge pops, after which status reads 16'h0004.
- Glitch: press for 2 frames, then release → no event, status stays 16'h0000.
- Hold key 9 and key 3 simultaneously → single press event with code 3.
- With the macro defined, press then release key 5 → FIFO holds 16'h0005 then 16'h8005. Without the macro, FIFO holds only 16'h0005.
- DEPTH=2, three press/release cycles with no ack:
  - status reads 16'h0203 (count 2, overflow);
  - ack with statusordata=1 gives 16'h0201;
  - two data acks return the first two codes.
- Assert rst mid-frame with 1 entry queued → rowwrite returns to 4'b1110 and keyout is 16'h0000 for both selects.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: row-slot scan, per-frame debounce, key-event FIFO, polled status/data port.
// Optional build macro KEYPAD_RELEASE_EVENT_EN adds release events (rel bit) to the FIFO.
`timescale 1ns/1ps
module keypad_scan_fifo #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 32768,
  parameter int DEBOUNCE = 3,
  parameter int DEPTH    = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ROWS-1:0] rowwrite,
  input  logic [COLS-1:0] colread,
  input  logic            ack,
  input  logic            statusordata,
  output logic [15:0]     keyout
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int ENTRY_W = CODE_W + 1;
`else
  localparam int ENTRY_W = CODE_W;
`endif
  localparam logic [3:0] DB_TH = 4'(DEBOUNCE);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  logic [COLS-1:0]    r_col_s1, r_col_s2;
  logic [DIV_W-1:0]   r_div;
  logic [ROW_W-1:0]   r_row;
  logic               r_fr_vld;
  logic [CODE_W-1:0]  r_fr_code;
  logic               r_prev_vld;
  logic [CODE_W-1:0]  r_prev_code;
  logic [3:0]         r_dbc;
  state_t             r_state;
  logic [CODE_W-1:0]  r_key;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_ack_q;

  logic [COLS-1:0]    w_pressed;
  logic [COL_W-1:0]   w_col_idx;
  logic               w_row_hit;
  logic [CODE_W-1:0]  w_row_code;
  logic               w_tick, w_frame_end;
  logic               w_cand_vld;
  logic [CODE_W-1:0]  w_cand_code;
  logic               w_same;
  logic [3:0]         w_dbc_nxt;
  logic               w_press, w_release, w_push, w_wr, w_pop, w_clr, w_drop;
  logic               w_full, w_ready;
  logic [ENTRY_W-1:0] w_push_data, w_head;

  // Synchronizer stage: colread is asynchronous to clk
  always_ff @(posedge clk) begin
    r_col_s1 <= colread;
    r_col_s2 <= r_col_s1;
  end

  assign w_pressed = ~r_col_s2;
  assign w_row_hit = |w_pressed;

  // Lowest pressed column in the current row
  always_comb begin
    w_col_idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_pressed[c]) w_col_idx = COL_W'(c);
    end
  end

  assign w_row_code  = CODE_W'(int'(r_row) * COLS + int'(w_col_idx));
  assign w_tick      = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_tick && (r_row == ROW_W'(ROWS - 1));

  // Rows are scanned in ascending order, so the first hit of a frame is the lowest code
  assign w_cand_vld  = r_fr_vld | w_row_hit;
  assign w_cand_code = r_fr_vld ? r_fr_code : w_row_code;
  assign w_same      = (w_cand_vld == r_prev_vld) && (!w_cand_vld || (w_cand_code == r_prev_code));
  assign w_dbc_nxt   = !w_same ? 4'd1 : ((r_dbc == 4'd15) ? 4'd15 : r_dbc + 4'd1);

  assign w_press   = w_frame_end && (r_state == S_IDLE) && w_cand_vld && (w_dbc_nxt >= DB_TH);
  assign w_release = w_frame_end && (r_state == S_HELD) && !(w_cand_vld && (w_cand_code == r_key))
                     && (w_dbc_nxt >= DB_TH);

`ifdef KEYPAD_RELEASE_EVENT_EN
  assign w_push      = w_press | w_release;
  assign w_push_data = {w_release, (w_release ? r_key : w_cand_code)};
`else
  assign w_push      = w_press;
  assign w_push_data = w_cand_code;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_row      <= '0;
      rowwrite   <= {{(ROWS-1){1'b1}}, 1'b0};
      r_fr_vld   <= 1'b0;
    end else if (w_tick) begin
      r_div    <= '0;
      rowwrite <= {rowwrite[ROWS-2:0], rowwrite[ROWS-1]};
      r_row    <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
      if (w_frame_end) begin
        r_fr_vld <= 1'b0;
      end else if (!r_fr_vld && w_row_hit) begin
        r_fr_vld  <= 1'b1;
        r_fr_code <= w_row_code;
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Debounce stage: candidate history, counter and debounced key state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prev_vld <= 1'b0;
      r_dbc      <= 4'd0;
    end else if (w_frame_end) begin
      r_prev_vld  <= w_cand_vld;
      r_prev_code <= w_cand_code;
      r_dbc       <= w_dbc_nxt;
      if (w_press) begin
        r_state <= S_HELD;
        r_key   <= w_cand_code;
      end else if (w_release) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_ready = (r_cnt != '0);
  assign w_pop   = ack && !r_ack_q && !statusordata && w_ready;
  assign w_clr   = ack && !r_ack_q && statusordata;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr];

  // FIFO stage
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_ack_q <= 1'b0;
    end else begin
      r_ack_q <= ack;
      if (w_wr)  r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    keyout = 16'h0000;
    if (statusordata) begin
      keyout = {8'(r_cnt), 5'b00000, (r_state == S_HELD), r_ovf, w_ready};
    end else if (w_ready) begin
      keyout[7:0] = 8'(w_head[CODE_W-1:0]);
`ifdef KEYPAD_RELEASE_EVENT_EN
      keyout[15] = w_head[CODE_W];
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: keypad matrix model, scoreboard queues of expected FIFO words.
`timescale 1ns/1ps
module tb_keypad_scan_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rowwrite1, rowwrite2;
  logic [3:0]  colread1, colread2;
  logic        ack1, ack2, sel1, sel2;
  logic [15:0] keyout1, keyout2;
  logic [15:0] keys1, keys2;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb1[$];
  logic [15:0] sb2[$];
  logic        ovf2;

  always #5 clk = ~clk;

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .rowwrite(rowwrite1), .colread(colread1),
    .ack(ack1), .statusordata(sel1), .keyout(keyout1));

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .rowwrite(rowwrite2), .colread(colread2),
    .ack(ack2), .statusordata(sel2), .keyout(keyout2));

  // Keypad matrix: a held key pulls its column low while its row is driven low
  always_comb begin
    colread1 = 4'hF;
    colread2 = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rowwrite1[r] && keys1[r*4+c]) colread1[c] = 1'b0;
        if (!rowwrite2[r] && keys2[r*4+c]) colread2[c] = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ack1_pulse();
    ack1 = 1'b1; tick(1);
    ack1 = 1'b0; tick(1);
  endtask

  task automatic ack2_pulse();
    ack2 = 1'b1; tick(1);
    ack2 = 1'b0; tick(1);
  endtask

  task automatic drain1();
    sel1 = 1'b0; #1;
    while (sb1.size() > 0) begin
      check("data1", keyout1, sb1.pop_front());
      ack1_pulse();
    end
    check("data1_empty", keyout1, 16'h0000);
  endtask

  task automatic push2(input logic [15:0] e);
    if (sb2.size() < 2) sb2.push_back(e);
    else ovf2 = 1'b1;
  endtask

  function automatic logic [15:0] status_exp(input int cnt, input logic held, input logic ovf);
    return {8'(cnt), 5'b00000, held, ovf, (cnt != 0)};
  endfunction

  initial begin
    int codes2[3];
    codes2 = '{1, 6, 12};
    rst = 1'b1; ack1 = 1'b0; ack2 = 1'b0; sel1 = 1'b1; sel2 = 1'b1;
    keys1 = 16'h0000; keys2 = 16'h0000; ovf2 = 1'b0;
    tick(3);
    check("rst_rowwrite", {12'h000, rowwrite1}, 16'h000E);
    check("rst_status", keyout1, 16'h0000);
    sel1 = 1'b0; #1;
    check("rst_data", keyout1, 16'h0000);
    rst = 1'b0;
    tick(2);

    // Key 9 (row2/col1) held for five frames
    keys1 = 16'h0200; sb1.push_back(16'h0009);
    tick(80);
    sel1 = 1'b1; #1;
    check("press9_status", keyout1, 16'h0105);
    sel1 = 1'b0; #1;
    check("press9_data", keyout1, sb1.pop_front());
    ack1_pulse();
    sel1 = 1'b1; #1;
    check("press9_after_pop", keyout1, 16'h0004);

    keys1 = 16'h0000;
`ifdef KEYPAD_RELEASE_EVENT_EN
    sb1.push_back(16'h8009);
`endif
    tick(80);
    check("release9_status", keyout1, status_exp(sb1.size(), 1'b0, 1'b0));
    drain1();

    // Glitch: two frames only
    keys1 = 16'h0200;
    tick(30);
    keys1 = 16'h0000;
    tick(80);
    sel1 = 1'b1; #1;
    check("glitch_status", keyout1, 16'h0000);

    // Keys 9 and 3 together: lower code wins
    keys1 = 16'h0208; sb1.push_back(16'h0003);
    tick(80);
    check("multi_status", keyout1, 16'h0105);
    keys1 = 16'h0000;
`ifdef KEYPAD_RELEASE_EVENT_EN
    sb1.push_back(16'h8003);
`endif
    tick(80);
    drain1();

    // Key 5 press then release, read back without intermediate acks
    keys1 = 16'h0020; sb1.push_back(16'h0005);
    tick(80);
    keys1 = 16'h0000;
`ifdef KEYPAD_RELEASE_EVENT_EN
    sb1.push_back(16'h8005);
`endif
    tick(80);
    sel1 = 1'b1; #1;
    check("key5_status", keyout1, status_exp(sb1.size(), 1'b0, 1'b0));
    drain1();

    // Overflow on the two-entry instance
    for (int i = 0; i < 3; i++) begin
      keys2 = 16'h0001 << codes2[i];
      push2(16'(codes2[i]));
      tick(80);
      keys2 = 16'h0000;
`ifdef KEYPAD_RELEASE_EVENT_EN
      push2(16'h8000 | 16'(codes2[i]));
`endif
      tick(80);
    end
    sel2 = 1'b1; #1;
    check("ovf_status", keyout2, 16'h0203);
    check("ovf_model", keyout2, status_exp(sb2.size(), 1'b0, ovf2));
    ack2_pulse();
    check("ovf_cleared", keyout2, 16'h0201);
    sel2 = 1'b0; #1;
    while (sb2.size() > 0) begin
      check("data2", keyout2, sb2.pop_front());
      ack2_pulse();
    end
    check("data2_empty", keyout2, 16'h0000);

    // Reset mid-frame with one entry queued and ack held high through reset
    keys1 = 16'h0020;
    tick(80);
    sel1 = 1'b1; #1;
    check("pre_rst_status", keyout1, 16'h0105);
    tick(5);
    ack1 = 1'b1; rst = 1'b1;
    tick(2);
    check("midrst_rowwrite", {12'h000, rowwrite1}, 16'h000E);
    check("midrst_status", keyout1, 16'h0000);
    sel1 = 1'b0; #1;
    check("midrst_data", keyout1, 16'h0000);
    keys1 = 16'h0000; sb1.delete();
    rst = 1'b0;
    tick(1);
    check("post_rst_data", keyout1, 16'h0000);
    sel1 = 1'b1; #1;
    check("post_rst_status", keyout1, 16'h0000);
    check("post_rst_rowwrite", {12'h000, rowwrite1}, 16'h000E);
    ack1 = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
